// File: rtl/enable_scheduler.sv
// enable_scheduler: round-robin clock-enable scheduler for a bank of enabler
// clock-gating cells. At most one enable is high at a time. Each grant lasts
// at most BURST cycles, and consecutive grants are separated by GAP_CYCLES
// cycles with every enable low.
//
// Ports:
//   clk       system clock, rising edge
//   reset_L   asynchronous active-low reset
//   req       per-requester level request
//   done      per-requester early release (only the grantee's bit is used)
//   enb       registered one-hot-or-zero enables, one per enabler instance
//   gnt_id    index of the current or most recent grantee
//   busy      high while in GRANT or GAP
//   grant_cnt saturating count of grants issued     (GRANT_CNT_EN only)
//   overrun   sticky flag: a grant expired while still requested (GRANT_CNT_EN only)
//
// Optional feature macro: GRANT_CNT_EN
module enable_scheduler #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned BURST      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned ID_W       = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  enb,
    output logic [ID_W-1:0]   gnt_id,
    output logic              busy
`ifdef GRANT_CNT_EN
    ,
    output logic [7:0]        grant_cnt,
    output logic              overrun
`endif
);

    localparam int unsigned BCW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  enb_nxt;
    logic [ID_W-1:0]   gnt_id_nxt;
    logic              busy_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [BCW-1:0]    burst_cnt, burst_cnt_nxt;
    logic [GCW-1:0]    gap_cnt, gap_cnt_nxt;
    logic [ID_W-1:0]   sel;
    logic              found;
    logic              take_c;
    int unsigned       arb_idx;

    // Round-robin pick: first asserted req starting at rr_ptr, wrapping.
    always_comb begin
        sel     = '0;
        found   = 1'b0;
        arb_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arb_idx = (32'(rr_ptr) + i) % N_REQ;
            if (!found && req[ID_W'(arb_idx)]) begin
                sel   = ID_W'(arb_idx);
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        enb_nxt       = enb;
        gnt_id_nxt    = gnt_id;
        busy_nxt      = busy;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        gap_cnt_nxt   = gap_cnt;
        take_c        = 1'b0;
        case (state)
            IDLE: begin
                take_c = found;
            end
            GRANT: begin
                if (burst_cnt == '0 || done[gnt_id] || !req[gnt_id]) begin
                    enb_nxt     = '0;
                    rr_ptr_nxt  = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    gap_cnt_nxt = GCW'(GAP_CYCLES - 1);
                    state_nxt   = GAP;
                end else begin
                    burst_cnt_nxt = burst_cnt - BCW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (found) begin
                        take_c = 1'b1;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - GCW'(1);
                end
            end
            default: begin
                enb_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
        // New grant, shared by IDLE and end-of-gap arbitration.
        if (take_c) begin
            enb_nxt       = N_REQ'(1) << sel;
            gnt_id_nxt    = sel;
            busy_nxt      = 1'b1;
            burst_cnt_nxt = BCW'(BURST - 1);
            state_nxt     = GRANT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs and counters.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            enb       <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            enb       <= enb_nxt;
            gnt_id    <= gnt_id_nxt;
            busy      <= busy_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
        end
    end

`ifdef GRANT_CNT_EN
    // Grant statistics: saturating grant count and sticky burst-expiry flag.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grant_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (take_c && grant_cnt != 8'hFF) begin
                grant_cnt <= grant_cnt + 8'd1;
            end
            if (state == GRANT && burst_cnt == '0 && req[gnt_id]) begin
                overrun <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_enable_scheduler.sv
// Directed self-checking bench for enable_scheduler (N_REQ=4, BURST=4,
// GAP_CYCLES=1). Inputs change on the falling edge; outputs are sampled on
// the following falling edge.
module tb_enable_scheduler;

    logic       clk;
    logic       reset_L;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] enb;
    logic [1:0] gnt_id;
    logic       busy;
`ifdef GRANT_CNT_EN
    logic [7:0] grant_cnt;
    logic       overrun;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    enable_scheduler #(
        .N_REQ(4), .BURST(4), .GAP_CYCLES(1), .ID_W(2)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .req(req),
        .done(done),
        .enb(enb),
        .gnt_id(gnt_id),
        .busy(busy)
`ifdef GRANT_CNT_EN
        ,
        .grant_cnt(grant_cnt),
        .overrun(overrun)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #30 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        req     = '0;
        done    = '0;
        tick();
        reset_L = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_enb;
        reset_L = 1'b0;
        req     = 4'b1111;
        done    = '0;

        // 1. Reset holds everything low despite requests.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_enb", enb, 4'b0000);
            check("rst_gnt", gnt_id, 0);
            check("rst_busy", busy, 0);
        end
        reset_L = 1'b1;
        tick();
        check("rst_first_enb", enb, 4'b0001);
        check("rst_first_busy", busy, 1);

        // 2. Single requester: 4 high, 1 gap, re-granted.
        apply_reset();
        req = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_enb = (k == 4) ? 4'b0000 : 4'b0100;
            check("single_enb", enb, exp_enb);
            check("single_gnt", gnt_id, 2);
            check("single_busy", busy, 1);
        end

        // 3. Full contention: grants 0,1,2,3,0 with a one-cycle gap.
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 25; k++) begin
            tick();
            exp_enb = ((k % 5) < 4) ? (4'b0001 << ((k / 5) % 4)) : 4'b0000;
            check("rr_enb", enb, exp_enb);
            check("rr_gnt", gnt_id, (k / 5) % 4);
            check("rr_onehot", ($countones(enb) <= 1) ? 1 : 0, 1);
        end

        // 4. Early release by done of grantee; foreign done ignored.
        apply_reset();
        req = 4'b0110;
        tick();
        check("early_c1", enb, 4'b0010);
        done = 4'b1000;
        tick();
        check("early_foreign_done", enb, 4'b0010);
        done = 4'b0010;
        tick();
        done = 4'b0000;
        check("early_release", enb, 4'b0000);
        check("early_gap_busy", busy, 1);
        tick();
        check("early_next", enb, 4'b0100);
        check("early_next_gnt", gnt_id, 2);

        // 5. Withdraw in the 3rd cycle, then async reset mid-grant.
        apply_reset();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wd_enb", enb, 4'b0001);
        end
        req = 4'b0000;
        tick();
        check("wd_release", enb, 4'b0000);
        check("wd_gap_busy", busy, 1);
        tick();
        check("wd_idle_busy", busy, 0);
        check("wd_idle_gnt", gnt_id, 0);
        req = 4'b0100;
        tick();
        check("wd_regrant", enb, 4'b0100);
        @(posedge clk);
        #10 reset_L = 1'b0;
        #1;
        check("async_enb", enb, 4'b0000);
        check("async_busy", busy, 0);
        check("async_gnt", gnt_id, 0);
        @(negedge clk);
        req = 4'b1111;
        tick();
        reset_L = 1'b1;
        tick();
        check("post_rst_enb", enb, 4'b0001);
        check("post_rst_gnt", gnt_id, 0);

`ifdef GRANT_CNT_EN
        // 6. Grant counter saturates, overrun latches on burst expiry.
        apply_reset();
        req = 4'b1111;
        tick();
        check("cnt_first", grant_cnt, 1);
        check("ovr_first", overrun, 0);
        for (int k = 1; k < 5 * 300; k++) tick();
        check("cnt_sat", grant_cnt, 8'hFF);
        check("ovr_sticky", overrun, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
